instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming MIPS instruction encoder: accepts one instruction descriptor per handshake (mnemonic code plus register, shift, immediate and target fields) and emits the packed 32-bit machine word with its word address. The encoding table is the exact inverse of the pipeline's `control_unit` decode table. It feeds the instruction-memory write port during program load and in self-test benches, sitting upstream of instruction memory. Output is a 2-entry skid buffer with valid/ready backpressure.

## Interface
- `ADDR_WIDTH`, 8, width of the instruction-memory word address.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  pulse; in IDLE, loads `base_addr_i` and enters RUN.
- `base_addr_i`  in  ADDR_WIDTH  first word address.
- `valid_i`  in  1  descriptor valid.
- `ready_o`  out  1  descriptor accepted when `valid_i && ready_o`.
- `last_i`  in  1  accepted descriptor is the final one.
- `mnem_i`  in  5  mnemonic code: 0 SLL, 1 SRL, 2 SRA, 3 JR, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 SLT, 9 J, 10 JAL, 11 BEQ, 12 BNE, 13 ADDI, 14 SLTI, 15 ANDI, 16 ORI, 17 LW, 18 SW.
- `rs_i`, `rt_i`, `rd_i`, `shamt_i`  in  5 each  register and shift fields.
- `imm_i`  in  16  immediate or branch offset.
- `target_i`  in  26  jump target.
- `word_valid_o`  out  1  buffered word available.
- `word_ready_i`  in  1  consumer takes word when `word_valid_o && word_ready_i`.
- `word_o`  out  32  encoded instruction.
- `addr_o`  out  ADDR_WIDTH  address of `word_o`.
- `done_o`  out  1  one-cycle pulse: program fully drained.
- `err_o`  out  1  sticky: illegal mnemonic seen since the last `start_i`.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start_i`. Address counter loads `base_addr_i`; `err_o` clears.
  - RUN → DRAIN on accepting a descriptor with `last_i`.
  - DRAIN → IDLE when the buffer is empty (and, with the macro, no pad is pending). `done_o` pulses in that cycle.
  - `start_i` is ignored outside IDLE.
- `ready_o` = RUN && buffer occupancy < 2 (registered occupancy) && no pad pending.
- Encoding:
  - R-type: {000000, rs, rt, rd, shamt, funct}, funct SLL 000000, SRL 000010, SRA 000011, JR 001000, ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - Shifts force rs=0; SLL/SRL/SRA use `shamt_i`, all other R-type force shamt=0.
  - JR forces rt=rd=shamt=0.
  - J/JAL: {000010/000011, target}.
  - I-type: {op, rs, rt, imm}, op BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, LW 100011, SW 101011.
- Codes 19–31 (illegal): the descriptor is accepted and consumed, no word is emitted, the address does not advance, `err_o` sets.
- Each emitted word takes the current address; the counter then increments modulo 2^ADDR_WIDTH. Wrap-around is silent.
- Buffer is FIFO-ordered. Push and pop in the same cycle leave occupancy unchanged.

## Timing
- Reset values: state IDLE, occupancy 0, address 0, all outputs 0 (`ready_o`, `word_valid_o`, `word_o`, `addr_o`, `done_o`, `err_o`).
- Latency: a descriptor accepted at edge k gives `word_valid_o`=1 with its word from edge k onward, i.e. visible in cycle k+1.
- Throughput: 1 word/cycle while `word_ready_i`=1.
- `word_o`/`addr_o` hold stable while `word_valid_o && !word_ready_i`.
- Reset mid-operation flushes the buffer and returns to IDLE; no partial word is emitted.
- `last_i` on an illegal descriptor still moves to DRAIN.

## Configuration
- `ENCODER_DELAY_SLOT_PAD_EN` defined:
  - After every J, JAL, JR, BEQ or BNE word, the encoder pushes NOP 0x00000000 at the next address.
  - `ready_o` is low from the branch accept until the pad is pushed.
  - A pad pending on `last_i` is emitted before `done_o`.
- Undefined: no padding; the pad logic is absent.

## Test plan
- Reset, `start_i` with base 0x10, ADD rd=3 rs=1 rt=2, `last_i` → `word_o`=0x00221820, `addr_o`=0x10, one cycle after accept; `done_o` pulses after the pop.
- LW rt=8 rs=29 imm=0x0004; SLL rd=2 rt=1 shamt=4; BEQ rs=1 rt=2 imm=0xFFFF; J target=0x10 → 0x8FA80004, 0x00011100, 0x1022FFFF, 0x08000010 at consecutive addresses.
- `word_ready_i`=0 while streaming 3 descriptors → `ready_o` drops after 2 accepts, words held stable; release → in-order output, no loss.
- Mnemonic 25 between two ADDs → `err_o`=1 sticky, only 2 words, addresses contiguous; next `start_i` clears `err_o`.
- ADDR_WIDTH=4, base 15, two words → `addr_o` 15 then 0; reset asserted with occupancy 2 → outputs 0 next cycle.
- With `ENCODER_DELAY_SLOT_PAD_EN`: BNE then ADDI → BNE word, 0x00000000, ADDI word at addresses n, n+1, n+2.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor input stream, word output stream and program control of instr_encoder.
interface instr_encoder_if #(parameter int ADDR_WIDTH = 8);
   logic                  start_i;
   logic [ADDR_WIDTH-1:0] base_addr_i;
   logic                  valid_i;
   logic                  ready_o;
   logic                  last_i;
   logic [4:0]            mnem_i;
   logic [4:0]            rs_i;
   logic [4:0]            rt_i;
   logic [4:0]            rd_i;
   logic [4:0]            shamt_i;
   logic [15:0]           imm_i;
   logic [25:0]           target_i;
   logic                  word_valid_o;
   logic                  word_ready_i;
   logic [31:0]           word_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic                  done_o;
   logic                  err_o;
   modport master (
      output start_i, base_addr_i, valid_i, last_i, mnem_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i, word_ready_i,
      input  ready_o, word_valid_o, word_o, addr_o, done_o, err_o
   );
   modport slave (
      input  start_i, base_addr_i, valid_i, last_i, mnem_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i, word_ready_i,
      output ready_o, word_valid_o, word_o, addr_o, done_o, err_o
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS instruction descriptors into addressed words through a 2-entry skid buffer.
// Define ENCODER_DELAY_SLOT_PAD_EN to follow every J/JAL/JR/BEQ/BNE word with a NOP at the next address.
module instr_encoder #(parameter int ADDR_WIDTH = 8) (
   input  logic           clk_i,
   input  logic           rst_i,
   instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  rd_q, rd_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  err_q, err_d;
   logic [31:0]           wbuf_q [2];
   logic [31:0]           wbuf_d [2];
   logic [ADDR_WIDTH-1:0] abuf_q [2];
   logic [ADDR_WIDTH-1:0] abuf_d [2];
   logic [31:0]           enc, push_word;
   logic                  legal, accept, pop, push, pend, begin_ok;
`ifdef ENCODER_DELAY_SLOT_PAD_EN
   logic                  pad_q, pad_d, pad_push, br;
   assign pend = pad_q;
`else
   assign pend = 1'b0;
`endif
   assign bus.ready_o      = state_q == RUN && cnt_q != 2'd2 && !pend;
   assign bus.word_valid_o = cnt_q != 2'd0;
   assign bus.word_o       = bus.word_valid_o ? wbuf_q[rd_q] : '0;
   assign bus.addr_o       = bus.word_valid_o ? abuf_q[rd_q] : '0;
   assign bus.done_o       = state_q == DRAIN && cnt_q == 2'd0 && !pend;
   assign bus.err_o        = err_q;
   always_comb begin
      legal = 1'b1;
      enc = '0;
      case (bus.mnem_i)
         5'd0:    enc = {11'd0, bus.rt_i, bus.rd_i, bus.shamt_i, 6'h00};
         5'd1:    enc = {11'd0, bus.rt_i, bus.rd_i, bus.shamt_i, 6'h02};
         5'd2:    enc = {11'd0, bus.rt_i, bus.rd_i, bus.shamt_i, 6'h03};
         5'd3:    enc = {6'd0, bus.rs_i, 15'd0, 6'h08};
         5'd4:    enc = {6'd0, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h20};
         5'd5:    enc = {6'd0, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h22};
         5'd6:    enc = {6'd0, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h24};
         5'd7:    enc = {6'd0, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h25};
         5'd8:    enc = {6'd0, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h2a};
         5'd9:    enc = {6'h02, bus.target_i};
         5'd10:   enc = {6'h03, bus.target_i};
         5'd11:   enc = {6'h04, bus.rs_i, bus.rt_i, bus.imm_i};
         5'd12:   enc = {6'h05, bus.rs_i, bus.rt_i, bus.imm_i};
         5'd13:   enc = {6'h08, bus.rs_i, bus.rt_i, bus.imm_i};
         5'd14:   enc = {6'h0a, bus.rs_i, bus.rt_i, bus.imm_i};
         5'd15:   enc = {6'h0c, bus.rs_i, bus.rt_i, bus.imm_i};
         5'd16:   enc = {6'h0d, bus.rs_i, bus.rt_i, bus.imm_i};
         5'd17:   enc = {6'h23, bus.rs_i, bus.rt_i, bus.imm_i};
         5'd18:   enc = {6'h2b, bus.rs_i, bus.rt_i, bus.imm_i};
         default: legal = 1'b0;
      endcase
   end
   always_comb begin
      accept = bus.valid_i && bus.ready_o;
      pop = bus.word_valid_o && bus.word_ready_i;
      begin_ok = state_q == IDLE && bus.start_i;
`ifdef ENCODER_DELAY_SLOT_PAD_EN
      br = bus.mnem_i inside {5'd3, 5'd9, 5'd10, 5'd11, 5'd12};
      pad_push = pad_q && cnt_q != 2'd2;
      pad_d = (accept && legal && br) || (pad_q && !pad_push);
      push = (accept && legal) || pad_push;
      push_word = pad_push ? 32'd0 : enc;
`else
      push = accept && legal;
      push_word = enc;
`endif
      cnt_d = cnt_q + 2'(push) - 2'(pop);
      rd_d = rd_q ^ pop;
      wbuf_d = wbuf_q;
      abuf_d = abuf_q;
      // push is only possible with a free slot, so the tail sits at head + occupancy
      if (push) begin
         wbuf_d[rd_q ^ cnt_q[0]] = push_word;
         abuf_d[rd_q ^ cnt_q[0]] = addr_q;
      end
      addr_d = begin_ok ? bus.base_addr_i : push ? addr_q + ADDR_WIDTH'(1) : addr_q;
      err_d = begin_ok ? 1'b0 : (accept && !legal) || err_q;
      state_d = begin_ok ? RUN : (state_q == RUN && accept && bus.last_i) ? DRAIN : bus.done_o ? IDLE : state_q;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q <= '0;
         rd_q <= 1'b0;
         addr_q <= '0;
         err_q <= 1'b0;
         wbuf_q <= '{default: '0};
         abuf_q <= '{default: '0};
`ifdef ENCODER_DELAY_SLOT_PAD_EN
         pad_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         rd_q <= rd_d;
         addr_q <= addr_d;
         err_q <= err_d;
         wbuf_q <= wbuf_d;
         abuf_q <= abuf_d;
`ifdef ENCODER_DELAY_SLOT_PAD_EN
         pad_q <= pad_d;
`endif
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a table-driven encoding model.
module tb_instr_encoder;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int checks = 0;
   int errors = 0;
   bit rand_rdy = 1'b0;
   logic [31:0] got_w[$], exp_w[$];
   logic [7:0] got_a[$], exp_a[$];
   logic [7:0] maddr;
   int done_n = 0;
   logic [31:0] funct_t [9] = '{32'h00, 32'h02, 32'h03, 32'h08, 32'h20, 32'h22, 32'h24, 32'h25, 32'h2a};
   logic [31:0] op_t [8] = '{32'h04, 32'h05, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h23, 32'h2b};

   instr_encoder_if #(.ADDR_WIDTH(8)) bus ();
   instr_encoder #(.ADDR_WIDTH(8)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (bus.word_valid_o && bus.word_ready_i) begin
         got_w.push_back(bus.word_o);
         got_a.push_back(bus.addr_o);
      end
      if (bus.done_o) done_n++;
   end

   always @(posedge clk_i) if (rand_rdy) #1 bus.word_ready_i = 1'($urandom_range(0, 1));

   function automatic logic [31:0] ref_enc(input logic [31:0] m, rs, rt, rd, sh, imm, tgt, output bit legal, output bit br);
      legal = m <= 18;
      br = m == 3 || m == 9 || m == 10 || m == 11 || m == 12;
      if (m <= 2) return funct_t[m] | (sh << 6) | (rd << 11) | (rt << 16);
      if (m == 3) return funct_t[3] | (rs << 21);
      if (m <= 8) return funct_t[m] | (rd << 11) | (rt << 16) | (rs << 21);
      if (m <= 10) return ((m - 7) << 26) | tgt;
      if (m <= 18) return (op_t[m - 11] << 26) | (rs << 21) | (rt << 16) | imm;
      return 32'd0;
   endfunction

   task automatic begin_prog(input logic [7:0] base);
      got_w.delete(); got_a.delete(); exp_w.delete(); exp_a.delete();
      done_n = 0;
      maddr = base;
      @(posedge clk_i); #1;
      bus.base_addr_i = base;
      bus.start_i = 1'b1;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
   endtask

   task automatic send(input logic [4:0] m, rs, rt, rd, sh, input logic [15:0] imm, input logic [25:0] tgt, input bit l);
      bit lg, br;
      logic [31:0] w;
      int n = 0;
      w = ref_enc(32'(m), 32'(rs), 32'(rt), 32'(rd), 32'(sh), 32'(imm), 32'(tgt), lg, br);
      bus.valid_i = 1'b1; bus.mnem_i = m; bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd;
      bus.shamt_i = sh; bus.imm_i = imm; bus.target_i = tgt; bus.last_i = l;
      @(negedge clk_i);
      while (!bus.ready_o && n < 300) begin @(negedge clk_i); n++; end
      checks++;
      if (!bus.ready_o) begin errors++; $display("FAIL send_timeout mnem=%0d ready_o stayed 0 for %0d cycles", m, n); end
      @(posedge clk_i); #1;
      bus.valid_i = 1'b0; bus.last_i = 1'b0;
      if (lg) begin exp_w.push_back(w); exp_a.push_back(maddr); maddr++; end
`ifdef ENCODER_DELAY_SLOT_PAD_EN
      if (lg && br) begin exp_w.push_back(32'd0); exp_a.push_back(maddr); maddr++; end
`endif
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge clk_i);
         ok = bus.done_o;
      end
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.ready_o); end
      checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %b want 0", bus.word_valid_o); end
      checks++; if (bus.word_o !== 32'd0 || bus.addr_o !== 8'd0) begin errors++; $display("FAIL rst_word got %h/%h want 0/0", bus.word_o, bus.addr_o); end
      checks++; if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_flags done=%b err=%b want 0/0", bus.done_o, bus.err_o); end
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", bus.ready_o); end
   endtask

   task automatic test_basic();
      bit ok;
      bus.word_ready_i = 1'b1;
      begin_prog(8'h10);
      send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
      checks++; if (bus.word_valid_o !== 1'b1 || bus.word_o !== 32'h00221820 || bus.addr_o !== 8'h10) begin
         errors++; $display("FAIL basic_latency got v=%b %h@%h want 1 00221820@10", bus.word_valid_o, bus.word_o, bus.addr_o); end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done no done_o pulse"); end
      @(negedge clk_i);
      checks++; if (bus.done_o !== 1'b0 || done_n != 1) begin errors++; $display("FAIL basic_pulse done=%b count=%0d want 0/1", bus.done_o, done_n); end
      checks++; if (got_w.size() != 1 || got_w[0] !== 32'h00221820 || got_a[0] !== 8'h10) begin
         errors++; $display("FAIL basic_word got %0d words want 1 word 00221820@10", got_w.size()); end
   endtask

   task automatic test_vectors();
      bit ok;
      bus.word_ready_i = 1'b1;
      begin_prog(8'h20);
      send(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
      send(5'd0, 5'd0, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
      send(5'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'hffff, 26'h0, 1'b0);
      send(5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL vec_done no done_o pulse"); end
      checks++; if (got_w.size() < 2 || got_w[0] !== 32'h8fa80004 || got_w[1] !== 32'h00011100) begin
         errors++; $display("FAIL vec_lw_sll got %0d words, first %h want 8fa80004 00011100", got_w.size(), got_w.size() ? got_w[0] : 32'd0); end
      checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL vec_count got %0d want %0d", got_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++; if (got_w[i] !== exp_w[i] || got_a[i] !== exp_a[i]) begin
            errors++; $display("FAIL vec_word[%0d] got %h@%h want %h@%h", i, got_w[i], got_a[i], exp_w[i], exp_a[i]); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [31:0] w0;
      logic [7:0] a0;
      bus.word_ready_i = 1'b0;
      begin_prog(8'h40);
      send(5'd4, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0, 1'b0);
      send(5'd5, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0, 26'h0, 1'b0);
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0 with 2 buffered", bus.ready_o); end
      w0 = bus.word_o; a0 = bus.addr_o;
      checks++; if (w0 !== exp_w[0] || a0 !== exp_a[0]) begin errors++; $display("FAIL bp_head got %h@%h want %h@%h", w0, a0, exp_w[0], exp_a[0]); end
      repeat (3) begin
         @(negedge clk_i);
         checks++; if (bus.word_o !== w0 || bus.addr_o !== a0 || bus.word_valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_hold got v=%b %h@%h want 1 %h@%h", bus.word_valid_o, bus.word_o, bus.addr_o, w0, a0); end
      end
      fork
         send(5'd7, 5'd11, 5'd12, 5'd13, 5'd0, 16'h0, 26'h0, 1'b1);
         begin repeat (4) @(posedge clk_i); #1 bus.word_ready_i = 1'b1; end
      join
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_done no done_o pulse"); end
      checks++; if (got_w.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++; if (got_w[i] !== exp_w[i] || got_a[i] !== exp_a[i]) begin
            errors++; $display("FAIL bp_word[%0d] got %h@%h want %h@%h", i, got_w[i], got_a[i], exp_w[i], exp_a[i]); end
      end
   endtask

   task automatic test_illegal();
      bit ok;
      bus.word_ready_i = 1'b1;
      begin_prog(8'h60);
      send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      send(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ill_err got %b want 1", bus.err_o); end
      send(5'd4, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1);
      wait_done(ok);
      checks++; if (!ok || bus.err_o !== 1'b1) begin errors++; $display("FAIL ill_sticky done=%b err=%b want 1/1", ok, bus.err_o); end
      checks++; if (got_w.size() != 2) begin errors++; $display("FAIL ill_count got %0d want 2", got_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++; if (got_w[i] !== exp_w[i] || got_a[i] !== exp_a[i]) begin
            errors++; $display("FAIL ill_word[%0d] got %h@%h want %h@%h", i, got_w[i], got_a[i], exp_w[i], exp_a[i]); end
      end
      begin_prog(8'h70);
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", bus.err_o); end
      send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
      wait_done(ok);
      checks++; if (!ok || got_w.size() != 0 || bus.err_o !== 1'b1) begin
         errors++; $display("FAIL ill_last done=%b words=%0d err=%b want 1/0/1", ok, got_w.size(), bus.err_o); end
   endtask

   task automatic test_wrap();
      bit ok;
      bus.word_ready_i = 1'b1;
      begin_prog(8'hff);
      send(5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
      send(5'd16, 5'd3, 5'd4, 5'd0, 5'd0, 16'habcd, 26'h0, 1'b1);
      wait_done(ok);
      checks++; if (!ok || got_w.size() != 2) begin errors++; $display("FAIL wrap_count done=%b words=%0d want 1/2", ok, got_w.size()); end
      checks++; if (got_a.size() != 2 || got_a[0] !== 8'hff || got_a[1] !== 8'h00) begin
         errors++; $display("FAIL wrap_addr got %0d addrs want ff then 00", got_a.size()); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++; if (got_w[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bus.word_ready_i = 1'b0;
      begin_prog(8'h80);
      send(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      send(5'd8, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++; if (bus.word_valid_o !== 1'b0 || bus.word_o !== 32'd0 || bus.addr_o !== 8'd0 || bus.ready_o !== 1'b0) begin
         errors++; $display("FAIL midrst got v=%b %h@%h rdy=%b want all 0", bus.word_valid_o, bus.word_o, bus.addr_o, bus.ready_o); end
      #1 rst_i = 1'b0;
      bus.word_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      checks++; if (got_w.size() != 0 || bus.done_o !== 1'b0) begin errors++; $display("FAIL midrst_flush words=%0d done=%b want 0/0", got_w.size(), bus.done_o); end
   endtask

   task automatic test_random();
      bit ok;
      int len;
      rand_rdy = 1'b1;
      for (int p = 0; p < 6; p++) begin
         begin_prog(8'($urandom));
         len = $urandom_range(1, 10);
         for (int k = 0; k < len; k++)
            send(5'($urandom_range(0, 22)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 26'($urandom), k == len - 1);
         wait_done(ok);
         checks++; if (!ok || got_w.size() != exp_w.size()) begin
            errors++; $display("FAIL rand%0d_count done=%b got %0d want %0d", p, ok, got_w.size(), exp_w.size()); end
         for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++; if (got_w[i] !== exp_w[i] || got_a[i] !== exp_a[i]) begin
               errors++; $display("FAIL rand%0d_word[%0d] got %h@%h want %h@%h", p, i, got_w[i], got_a[i], exp_w[i], exp_a[i]); end
         end
      end
      rand_rdy = 1'b0;
      #2 bus.word_ready_i = 1'b1;
   endtask

   task automatic test_pad();
      bit ok;
      bus.word_ready_i = 1'b1;
      begin_prog(8'h90);
      send(5'd12, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0);
      send(5'd13, 5'd5, 5'd6, 5'd0, 5'd0, 16'h7fff, 26'h0, 1'b1);
      wait_done(ok);
      checks++; if (!ok || got_w.size() != exp_w.size()) begin errors++; $display("FAIL pad_count done=%b got %0d want %0d", ok, got_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++; if (got_w[i] !== exp_w[i] || got_a[i] !== exp_a[i]) begin
            errors++; $display("FAIL pad_word[%0d] got %h@%h want %h@%h", i, got_w[i], got_a[i], exp_w[i], exp_a[i]); end
      end
   endtask

   initial begin
      bus.start_i = 1'b0; bus.base_addr_i = '0; bus.valid_i = 1'b0; bus.last_i = 1'b0;
      bus.mnem_i = '0; bus.rs_i = '0; bus.rt_i = '0; bus.rd_i = '0; bus.shamt_i = '0;
      bus.imm_i = '0; bus.target_i = '0; bus.word_ready_i = 1'b0;
      test_reset();
      test_basic();
      test_vectors();
      test_back_to_back();
      test_illegal();
      test_wrap();
      test_reset_mid();
      test_pad();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
